// File: rtl/serial_add_sched_if.sv
// ---------------------------------------------------------------------------
// serial_add_sched_if
//
// Purpose: bundles every non-clock signal of the bit-serial addition
// scheduler: two add-request ports, the link to the shared 1-bit full
// adder, and the result port.
//
// Handshake semantics (request and result ports alike): a transfer happens
// on a rising clock edge where VALID and READY are both high. The source
// keeps VALID and its payload steady until that edge; READY may depend
// combinationally on VALID, VALID never depends on READY.
//
// Signals:
//   req0_valid/req1_valid  requester has an add pending
//   req0_a/b, req1_a/b     WIDTH-bit operands
//   req0_ready/req1_ready  grant from the scheduler
//   req0_cin/req1_cin      initial carry (only with SERIAL_ADD_CIN_EN)
//   fa_a, fa_b, fa_cin     drive the shared full adder
//   fa_sum, fa_cout        combinational return of the full adder
//   res_valid/res_ready    result handshake
//   res_sum, res_cout      WIDTH-bit sum and carry out of the MSB
//   res_id                 requester that issued the result
//
// Modports:
//   master  the surroundings (requesters, adder cell, result consumer)
//   slave   the scheduler itself
//
// Optional feature macro: SERIAL_ADD_CIN_EN adds the per-requester carry in.
// ---------------------------------------------------------------------------
interface serial_add_sched_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
`ifdef SERIAL_ADD_CIN_EN
   logic             req0_cin;
   logic             req1_cin;
`endif
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_id;

   modport master (
`ifdef SERIAL_ADD_CIN_EN
      output req0_cin, req1_cin,
`endif
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  fa_a, fa_b, fa_cin,
      output fa_sum, fa_cout,
      input  res_valid, res_sum, res_cout, res_id,
      output res_ready
   );

   modport slave (
`ifdef SERIAL_ADD_CIN_EN
      input  req0_cin, req1_cin,
`endif
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      output req0_ready, req1_ready,
      output fa_a, fa_b, fa_cin,
      input  fa_sum, fa_cout,
      output res_valid, res_sum, res_cout, res_id,
      input  res_ready
   );
endinterface

// File: rtl/serial_add_sched.sv
// ---------------------------------------------------------------------------
// serial_add_sched
//
// Purpose: bit-serial addition scheduler. Two requesters share one external
// combinational 1-bit full adder. A round-robin arbiter picks a WIDTH-bit
// add request, the operands are fed LSB-first through the adder one bit per
// clock with COUT looped back into CIN, and the sum, final carry and
// requester ID are returned over a valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any job in flight
//   bus        serial_add_sched_if.slave (requests, adder link, result)
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature macro: SERIAL_ADD_CIN_EN. When defined, the initial
// carry of a job is taken from the granted requester's cin input; when
// undefined, every job starts with a carry of 0.
//
// Timing: handshake at edge t0, adder bits captured at edges t0+1..t0+WIDTH,
// res_valid high from edge t0+WIDTH until the result is accepted, then one
// IDLE cycle before the next grant.
// ---------------------------------------------------------------------------
module serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_sched_if.slave bus,
   output logic [1:0]        dbg_state
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic             prio_req1;   // 1: requester 1 wins the next tie
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_q;       // sum bits enter at the MSB and walk down
   logic             carry;
   logic [CW-1:0]    bit_cnt;
   logic             res_valid_q;
   logic             res_cout_q;
   logic             res_id_q;

   logic             grant0;
   logic             grant1;
   logic             take;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             cin_init;

   // Arbiter. Grants are only issued in IDLE and are held low while reset
   // is asserted so that every output reads 0 during reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && (state == IDLE)) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = ~prio_req1;
            grant1 = prio_req1;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   // A grant implies the matching valid, so either grant is a handshake.
   assign take  = grant0 | grant1;
   assign sel_a = grant1 ? bus.req1_a : bus.req0_a;
   assign sel_b = grant1 ? bus.req1_b : bus.req0_b;

`ifdef SERIAL_ADD_CIN_EN
   assign cin_init = grant1 ? bus.req1_cin : bus.req0_cin;
`else
   assign cin_init = 1'b0;
`endif

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // The adder inputs come straight from registers and are forced to 0
   // outside RUN, so the adder sees a quiet input whenever no job runs.
   assign bus.fa_a   = (state == RUN) & a_sh[0];
   assign bus.fa_b   = (state == RUN) & b_sh[0];
   assign bus.fa_cin = (state == RUN) & carry;

   assign bus.res_valid = res_valid_q;
   assign bus.res_sum   = sum_q;
   assign bus.res_cout  = res_cout_q;
   assign bus.res_id    = res_id_q;

   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         prio_req1   <= 1'b0;
         a_sh        <= '0;
         b_sh        <= '0;
         sum_q       <= '0;
         carry       <= 1'b0;
         bit_cnt     <= '0;
         res_valid_q <= 1'b0;
         res_cout_q  <= 1'b0;
         res_id_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  a_sh      <= sel_a;
                  b_sh      <= sel_b;
                  carry     <= cin_init;
                  bit_cnt   <= '0;
                  res_id_q  <= grant1;
                  // The requester just served loses the next tie.
                  prio_req1 <= grant0;
                  state     <= RUN;
               end
            end

            RUN: begin
               sum_q   <= {bus.fa_sum, sum_q[WIDTH-1:1]};
               carry   <= bus.fa_cout;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  res_cout_q  <= bus.fa_cout;
                  res_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end

            DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sched.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sched
//
// Purpose: self-checking bench for serial_add_sched (WIDTH = 8). Provides a
// behavioural full adder on the adder link, drives requests, predicts the
// arbiter's choice and the arithmetic, and compares every returned result
// against an expected queue. Prints one summary line at the end.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_add_sched;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   serial_add_sched_if #(.WIDTH(W)) bus ();

   serial_add_sched #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Shared full adder cell.
   assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
   assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           hs_cyc   = 0;
   logic         ptr_m    = 1'b0;   // 1: requester 1 wins the next tie
   logic         rv_prev  = 1'b0;
   logic [W+1:0] exp_q[$];          // {id, cout, sum}

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W+1:0] model_res(input logic id, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic cin);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      return {id, s};
   endfunction

   // Grant monitor: predicts the arbiter, checks the grant and pushes the
   // expected result of the job about to start.
   always @(negedge clk) begin : monitor
      logic         id_m;
      logic         c_m;
      logic [W-1:0] a_m;
      logic [W-1:0] b_m;
      if (!rst_n) begin
         ptr_m = 1'b0;
      end else if (bus.req0_ready || bus.req1_ready) begin
         id_m = (bus.req0_valid && bus.req1_valid) ? ptr_m : bus.req1_valid;
         check("grant", {bus.req1_ready, bus.req0_ready}, id_m ? 32'd2 : 32'd1);
         a_m = id_m ? bus.req1_a : bus.req0_a;
         b_m = id_m ? bus.req1_b : bus.req0_b;
`ifdef SERIAL_ADD_CIN_EN
         c_m = id_m ? bus.req1_cin : bus.req0_cin;
`else
         c_m = 1'b0;
`endif
         exp_q.push_back(model_res(id_m, a_m, b_m, c_m));
         ptr_m  = ~id_m;
         hs_cyc = cyc + 1;
      end
   end

   // Result collector: latency on the rising result, compare on accept.
   always @(negedge clk) begin : collector
      logic [W+1:0] e;
      if (rst_n) begin
         if (bus.res_valid && !rv_prev)
            check("latency", cyc - hs_cyc, W);
         if (bus.res_valid && bus.res_ready) begin
            check("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("res_sum",  bus.res_sum,  e[W-1:0]);
               check("res_cout", bus.res_cout, e[W]);
               check("res_id",   bus.res_id,   e[W+1]);
            end
         end
      end
      rv_prev = rst_n && bus.res_valid;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_grant_drop(input logic id);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 6 * W && !got; i++) begin
         @(negedge clk);
         got = id ? bus.req1_ready : bus.req0_ready;
      end
      check(id ? "grant1_seen" : "grant0_seen", got, 1);
      @(posedge clk);
      #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   // Drives one request; with trace set, follows every adder bit.
   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit trace);
      logic c;
      @(posedge clk);
      #1;
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end
`ifdef SERIAL_ADD_CIN_EN
      if (id) bus.req1_cin = cin;
      else    bus.req0_cin = cin;
`endif
      wait_grant_drop(id);
      if (trace) begin
         c = cin;
         for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("fa_bits", {bus.fa_a, bus.fa_b, bus.fa_cin}, {a[k], b[k], c});
            c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
         end
         @(negedge clk);
         check("fa_quiet", {bus.fa_a, bus.fa_b, bus.fa_cin}, 3'b000);
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 4 * W + 20 && !done; i++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !bus.res_valid;
      end
      check("drain", done, 1);
   endtask

   // Both requesters valid for four jobs: grants must alternate 0,1,0,1.
   task automatic both_test();
      logic [W-1:0] a0_t[2] = '{8'h10, 8'hA5};
      logic [W-1:0] b0_t[2] = '{8'h01, 8'h5B};
      logic [W-1:0] a1_t[2] = '{8'h80, 8'h33};
      logic [W-1:0] b1_t[2] = '{8'h80, 8'hCC};
      int   n0 = 0;
      int   n1 = 0;
      logic got;
      logic gid;
      @(posedge clk);
      #1;
      bus.req0_a = a0_t[0]; bus.req0_b = b0_t[0]; bus.req0_valid = 1'b1;
      bus.req1_a = a1_t[0]; bus.req1_b = b1_t[0]; bus.req1_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         got = 1'b0;
         gid = 1'b0;
         for (int i = 0; i < 4 * W + 10 && !got; i++) begin
            @(negedge clk);
            got = bus.req0_ready | bus.req1_ready;
            gid = bus.req1_ready;
         end
         check("alt_seen", got, 1);
         check("alt_order", gid, j[0]);
         @(posedge clk);
         #1;
         if (gid) begin
            n1++;
            if (n1 >= 2) bus.req1_valid = 1'b0;
            else begin bus.req1_a = a1_t[1]; bus.req1_b = b1_t[1]; end
         end else begin
            n0++;
            if (n0 >= 2) bus.req0_valid = 1'b0;
            else begin bus.req0_a = a0_t[1]; bus.req0_b = b0_t[1]; end
         end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      drain();
   endtask

   // Result held back for several cycles while another request waits.
   task automatic hold_test();
      logic seen;
      bus.res_ready = 1'b0;
      issue(1'b0, 8'hC3, 8'h5A, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.req1_a = 8'h11; bus.req1_b = 8'h22; bus.req1_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 2 * W && !seen; i++) begin
         @(negedge clk);
         seen = bus.res_valid;
      end
      check("hold_valid_seen", seen, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", bus.res_valid, 1);
         check("hold_sum",   bus.res_sum,   8'h1D);
         check("hold_cout",  bus.res_cout,  1);
         check("hold_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      end
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      wait_grant_drop(1'b1);
      drain();
   endtask

   // Reset in the middle of a job: everything clears, no result appears.
   task automatic reset_test();
      logic seen;
      issue(1'b0, 8'h1F, 8'h0B, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("pre_reset_fa", {bus.fa_a, bus.fa_b}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("arst_ready",   {bus.req1_ready, bus.req0_ready}, 2'b00);
      check("arst_fa",      {bus.fa_a, bus.fa_b, bus.fa_cin}, 3'b000);
      check("arst_valid",   bus.res_valid, 0);
      check("arst_sum",     bus.res_sum,   0);
      check("arst_cout_id", {bus.res_cout, bus.res_id}, 2'b00);
      check("arst_state",   dbg_state, 0);
      check("inflight_queued", exp_q.size(), 1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
      end
      check("no_result_after_reset", seen, 0);
      issue(1'b1, 8'h9D, 8'h64, 1'b0, 1'b1);
      drain();
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic         rid;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
`ifdef SERIAL_ADD_CIN_EN
      bus.req0_cin = 1'b0;
      bus.req1_cin = 1'b0;
`endif
      bus.res_ready = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      check("rst_ready",   {bus.req1_ready, bus.req0_ready}, 2'b00);
      check("rst_fa",      {bus.fa_a, bus.fa_b, bus.fa_cin}, 3'b000);
      check("rst_valid",   bus.res_valid, 0);
      check("rst_sum",     bus.res_sum,   0);
      check("rst_cout_id", {bus.res_cout, bus.res_id}, 2'b00);
      check("rst_state",   dbg_state, 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1);
      drain();
      issue(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
      drain();
      both_test();
      hold_test();
      reset_test();

      for (int n = 0; n < 6; n++) begin
         rid = 1'($urandom_range(0, 1));
         ra  = W'($urandom_range(0, 255));
         rb  = W'($urandom_range(0, 255));
`ifdef SERIAL_ADD_CIN_EN
         rc  = 1'($urandom_range(0, 1));
`else
         rc  = 1'b0;
`endif
         issue(rid, ra, rb, rc, 1'b1);
         drain();
      end

`ifdef SERIAL_ADD_CIN_EN
      issue(1'b0, 8'h7F, 8'h00, 1'b1, 1'b1);
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
